cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache. It accepts word-granular read requests from the icache and read/write requests from the dcache, grants one requester at a time, and drives the shared RAM port. It sits between the two cache-side `caches_if` connections and the RAM model/controller. Grants are registered and go to dcache first, with a starvation bound that guarantees icache forward progress.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive dcache grants allowed while `iREN` is pending before icache is forced to win the next arbitration.
- `CLK` in 1: single clock.
- `nRST` in 1: asynchronous active-low reset.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `iwait` out 1: 0 only in the cycle `iload` is valid for the granted icache request.
- `iload` out 32: read data to icache; `ramload` passthrough.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in 32: dcache word address.
- `dstore` in 32: dcache write data.
- `dwait` out 1: 0 only in the cycle the granted dcache access completes.
- `dload` out 32: read data to dcache; `ramload` passthrough.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: `ramstate_t`, one of FREE, BUSY, ACCESS, ERROR.

## Operation
- FSM states: IDLE, IGRANT, DGRANT.
- **IDLE:** no RAM enables.
  - Dcache request pending (`dREN|dWEN`) and not starving → DGRANT.
  - Else `iREN` → IGRANT.
  - Starving means `starve_cnt == STARVE_LIMIT` and `iREN`; icache then wins even if dcache is requesting.
- **DGRANT:**
  - `ramaddr=daddr`, `ramstore=dstore`.
  - `ramWEN=dWEN`; `ramREN=dREN & ~dWEN`. Write wins if both are asserted.
  - `ramstate==ACCESS` → `dwait=0` that cycle, next state IDLE.
  - Dcache drops both enables before ACCESS → abort: RAM enables low that same cycle (combinational), next state IDLE, `dwait` stays 1.
- **IGRANT:**
  - `ramaddr=iaddr`, `ramREN=1`, `ramWEN=0`.
  - ACCESS → `iwait=0`, next state IDLE.
  - `iREN` dropped → abort, same rules as DGRANT.
- **ramstate BUSY, FREE or ERROR while granted:** hold the grant, keep driving, keep the owner's wait high. ERROR is retried indefinitely, with no timeout.
- **`starve_cnt`** (width `$clog2(STARVE_LIMIT+1)`):
  - +1 on each completed dcache access while `iREN` is high, saturating at `STARVE_LIMIT`.
  - Cleared on each completed icache access, or when `iREN` is low in IDLE.
- **Non-owner:** wait held at 1 every cycle.
- **Data paths:** `iload` and `dload` always equal `ramload`; only the wait signals qualify them.
- **Dcache two-word block transfers:** not locked. The icache may interleave between word 0 and word 1 only via the starvation rule.

## Timing
- **Reset values:**
  - State IDLE, `starve_cnt=0`.
  - `iwait=1`, `dwait=1`.
  - `ramREN=0`, `ramWEN=0`, `ramaddr=0`, `ramstore=0`.
- **Reset mid-grant:** outputs return to reset values immediately (asynchronous); the in-flight access is dropped.
- **Latency:**
  - Request seen in IDLE at cycle N → RAM enable asserted at N+1.
  - Completion in the ACCESS cycle.
  - Mandatory one-cycle IDLE turnaround before the next grant.
  - Minimum request-to-completion is 2 cycles; back-to-back completions are at most every 2 cycles.
- **Requester obligations:** hold address, data and enables stable until its wait is low.
- **Simultaneous icache and dcache requests in IDLE:** dcache wins unless starving.

## Structure
- In `cpu_types_pkg`:
  - `ramstate_t` enum (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
  - `word_t`.
  - New `arb_state_t` enum.
- Flat single module, no sub-module. The FSM and the starvation counter are two `always_ff` blocks plus one `always_comb` for output and next-state logic.

## Test plan
- **Reset:** `iREN=1`, `dREN=1` held during reset → `ramREN=0`, `iwait=dwait=1`. First cycle after release: IDLE. Next cycle: DGRANT.
- **Simultaneous, no contention history:** `iREN` and `dREN` together; RAM gives ACCESS 2 cycles after enable → `dwait` low with `dload=ramload` first. Then IDLE. Then IGRANT and `iwait` low.
- **Starvation:** `STARVE_LIMIT=4`, `dREN` and `iREN` held continuously → exactly 4 dcache completions, then 1 icache completion, then dcache resumes.
- **Write priority:** `dREN=dWEN=1`, `daddr=0x100`, `dstore=0xDEADBEEF` → `ramWEN=1`, `ramREN=0`, `ramaddr=0x100`, `ramstore=0xDEADBEEF`.
- **Abort:** in IGRANT with `ramstate=BUSY`, drop `iREN` → `ramREN=0` that cycle, IDLE next cycle, `iwait` never low.
- **ERROR retry, then reset:** `ramstate=ERROR` for 5 cycles then ACCESS → grant held throughout and a single completion. Separately, assert `nRST` low mid-DGRANT → `ramWEN` drops immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared cache/RAM types for the memory arbiter
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache arbiter onto a single RAM port, dcache-first with starvation bound
module cache_mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   localparam int            CW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_t    state;
   arb_state_t    next_state;
   logic [CW-1:0] starve_cnt;
   logic          d_req;
   logic          starving;
   logic          d_done;
   logic          i_done;

   assign iload = ramload;
   assign dload = ramload;

   // Enables drop in the same cycle a requester withdraws, so the RAM never sees a stale access.
   always_comb begin
      d_req      = dREN | dWEN;
      starving   = iREN && (starve_cnt == LIMIT);
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      d_done     = 1'b0;
      i_done     = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && !starving) begin
               next_state = DGRANT;
            end else if (iREN) begin
               next_state = IGRANT;
            end
         end
         DGRANT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (!d_req) begin
               next_state = IDLE;
            end else begin
               ramWEN = dWEN;
               ramREN = dREN & ~dWEN;
               if (ramstate == ACCESS) begin
                  dwait      = 1'b0;
                  d_done     = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         IGRANT: begin
            ramaddr = iaddr;
            if (!iREN) begin
               next_state = IDLE;
            end else begin
               ramREN = 1'b1;
               if (ramstate == ACCESS) begin
                  iwait      = 1'b0;
                  i_done     = 1'b1;
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Counts dcache wins while the icache is waiting; saturates so the icache wins next.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         starve_cnt <= '0;
      end else if (i_done || (state == IDLE && !iREN)) begin
         starve_cnt <= '0;
      end else if (d_done && iREN && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench with behavioural RAM and arbitration-rule model
module tb_cache_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int LIMIT = 4;
   localparam int TMO   = 200;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN;
   word_t     iaddr, daddr, dstore;
   logic      iwait, dwait, ramREN, ramWEN;
   word_t     iload, dload, ramaddr, ramstore;
   word_t     ramload = '0;
   ramstate_t ramstate = FREE;

   typedef struct {
      logic  wr;
      word_t addr;
      word_t data;
   } req_t;

   req_t  i_exp[$];
   req_t  d_exp[$];
   byte   log_q[$];
   word_t ram_mem [256];
   word_t ref_mem [256];

   int checks = 0, errors = 0;
   int cyc = 0, last_done = -10, streak = 0;
   int ram_lat = 0, ram_err = 0, lat_left = 0, err_left = 0;
   bit ram_rand = 1'b0, ram_active = 1'b0;
   int la, lb, lc;
   string pattern;

   cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // RAM: a fresh access sees err_left ERROR cycles, then lat_left BUSY cycles, then ACCESS.
   always @(negedge CLK) begin
      if (nRST !== 1'b1 || !(ramREN || ramWEN)) begin
         ram_active = 1'b0;
         ramstate   = FREE;
         ramload    = $urandom;
      end else begin
         if (!ram_active) begin
            ram_active = 1'b1;
            lat_left   = ram_rand ? int'($urandom_range(0, 3)) : ram_lat;
            err_left   = ram_rand ? (($urandom_range(0, 7) == 0) ? 2 : 0) : ram_err;
         end
         if (err_left > 0) begin
            ramstate = ERROR;
            err_left--;
            ramload  = $urandom;
         end else if (lat_left > 0) begin
            ramstate = BUSY;
            lat_left--;
            ramload  = $urandom;
         end else begin
            ramstate   = ACCESS;
            ram_active = 1'b0;
            if (ramWEN) begin
               ram_mem[ramaddr[7:0]] = ramstore;
               ramload = $urandom;
            end else begin
               ramload = ram_mem[ramaddr[7:0]];
            end
         end
      end
   end

   // Scoreboard monitor
   always @(negedge CLK) begin
      req_t e;
      #3;
      if (nRST === 1'b1) begin
         if (!iwait || !dwait) begin
            check("wait_exclusive", iwait ^ dwait, 1);
            check("completion_spacing", (cyc - last_done) >= 2, 1);
            last_done = cyc;
         end
         if (!iwait) begin
            log_q.push_back("I");
            streak = 0;
            check("i_pending", i_exp.size() > 0, 1);
            if (i_exp.size() > 0) begin
               e = i_exp.pop_front();
               check("i_ramaddr", ramaddr, e.addr);
               check("i_ramren", {ramREN, ramWEN}, 2'b10);
               check("i_load", iload, ref_mem[e.addr[7:0]]);
            end
         end
         if (!dwait) begin
            log_q.push_back("D");
            check("d_pending", d_exp.size() > 0, 1);
            if (d_exp.size() > 0) begin
               e = d_exp.pop_front();
               check("d_ramaddr", ramaddr, e.addr);
               if (e.wr) begin
                  check("d_wr_enables", {ramREN, ramWEN}, 2'b01);
                  check("d_ramstore", ramstore, e.data);
                  ref_mem[e.addr[7:0]] = e.data;
               end else begin
                  check("d_rd_enables", {ramREN, ramWEN}, 2'b10);
                  check("d_load", dload, ref_mem[e.addr[7:0]]);
               end
            end
            if (iREN) begin
               streak++;
               check("starve_bound", streak <= LIMIT, 1);
            end
         end
         if (!iREN) streak = 0;
      end
   end

   task automatic wait_done(input bit icache, output int n);
      bit done = 1'b0;
      n = 0;
      while (!done && n < TMO) begin
         @(negedge CLK);
         #3;
         n++;
         done = icache ? !iwait : !dwait;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no completion after %0d cycles", icache ? "icache" : "dcache", n);
      end
      @(posedge CLK);
      #1;
      if (icache) iREN = 1'b0;
      else begin
         dREN = 1'b0;
         dWEN = 1'b0;
      end
   endtask

   task automatic icache_req(input word_t a, output int n);
      req_t r;
      r.wr = 1'b0; r.addr = a; r.data = '0;
      i_exp.push_back(r);
      iaddr = a;
      iREN  = 1'b1;
      wait_done(1'b1, n);
   endtask

   task automatic dcache_req(input logic ren, input logic wen, input word_t a, input word_t d, output int n);
      req_t r;
      r.wr = wen; r.addr = a; r.data = d;
      d_exp.push_back(r);
      daddr  = a;
      dstore = d;
      dREN   = ren;
      dWEN   = wen;
      wait_done(1'b0, n);
   endtask

   task automatic i_stream(input int count);
      int n;
      for (int k = 0; k < count; k++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
         icache_req(word_t'($urandom_range(0, 31)), n);
      end
   endtask

   task automatic d_stream(input int count);
      int n, op;
      for (int k = 0; k < count; k++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
         op = $urandom_range(0, 2);
         dcache_req(op != 1, op != 0, word_t'($urandom_range(0, 31)), $urandom, n);
      end
   endtask

   task automatic wait_enable(input bit wen_side, output int n);
      n = 0;
      while (!(wen_side ? ramWEN : ramREN) && n < 10) begin
         @(negedge CLK);
         #3;
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_t r;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = $urandom;
         ref_mem[i] = ram_mem[i];
      end

      // Reset with both requests held, then simultaneous arbitration
      nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
      iaddr = 32'h9; daddr = 32'h5; dstore = '0; ram_lat = 1;
      repeat (3) @(posedge CLK);
      #3;
      check("rst_ramren", ramREN, 0);
      check("rst_ramwen", ramWEN, 0);
      check("rst_iwait", iwait, 1);
      check("rst_dwait", dwait, 1);
      check("rst_ramaddr", ramaddr, 0);
      check("rst_ramstore", ramstore, 0);
      r.wr = 1'b0; r.addr = 32'h5; r.data = '0; d_exp.push_back(r);
      r.addr = 32'h9; i_exp.push_back(r);
      @(negedge CLK);
      nRST = 1'b1;
      #3 check("post_rst_idle", ramREN, 0);
      @(posedge CLK);
      #1;
      check("first_grant_ren", ramREN, 1);
      check("first_grant_addr", ramaddr, 32'h5);
      fork
         wait_done(1'b0, la);
         wait_done(1'b1, lb);
      join
      check("simul_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         check("simul_first", log_q[0], "D");
         check("simul_second", log_q[1], "I");
      end

      // Starvation: dcache back-to-back, icache held
      log_q.delete();
      ram_lat = 0;
      fork
         for (int k = 0; k < 6; k++) dcache_req(1'b1, 1'b0, 32'h20 + word_t'(k), '0, la);
         icache_req(32'h40, lb);
      join
      pattern = "DDDDIDD";
      check("starve_count", log_q.size(), 7);
      for (int k = 0; k < 7 && k < log_q.size(); k++) check($sformatf("starve_order_%0d", k), log_q[k], pattern[k]);

      // Write priority and minimum latency, then read-back by both caches
      dcache_req(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, la);
      check("write_latency", la, 2);
      dcache_req(1'b1, 1'b0, 32'h100, '0, la);
      icache_req(32'h100, la);

      // Icache abort while RAM is busy
      ram_lat = 20;
      iaddr = 32'h7; iREN = 1'b1;
      wait_enable(1'b0, la);
      check("abort_granted", ramREN, 1);
      @(posedge CLK);
      #1 iREN = 1'b0;
      #1 check("abort_ren_drop", ramREN, 0);
      @(posedge CLK);
      #1 check("abort_idle_addr", ramaddr, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         #3 check("abort_iwait_high", iwait, 1);
      end

      // ERROR retried until ACCESS
      ram_lat = 0; ram_err = 5;
      log_q.delete();
      @(posedge CLK);
      #1 dcache_req(1'b1, 1'b0, 32'h33, '0, la);
      check("err_latency", la, 7);
      check("err_single", log_q.size(), 1);
      ram_err = 0;

      // Asynchronous reset mid-grant
      ram_lat = 20;
      daddr = 32'h44; dstore = 32'h12345678; dREN = 1'b0; dWEN = 1'b1;
      wait_enable(1'b1, la);
      check("rstmid_granted", ramWEN, 1);
      @(negedge CLK);
      #2 nRST = 1'b0;
      #1;
      check("rstmid_wen", ramWEN, 0);
      check("rstmid_dwait", dwait, 1);
      check("rstmid_addr", ramaddr, 0);
      @(posedge CLK);
      #1 dWEN = 1'b0;
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      // Randomized traffic with random RAM latency and occasional errors
      ram_rand = 1'b1;
      fork
         i_stream(40);
         d_stream(60);
      join
      ram_rand = 1'b0;
      check("i_queue_empty", i_exp.size(), 0);
      check("d_queue_empty", d_exp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
